// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data wins by default; a stall counter forces a fetch grant after MAX_STALL denials.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_STALL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } owner_e;

  localparam logic [7:0] StallMax = 8'(MAX_STALL);

  owner_e            owner_q, owner_d;
  logic [7:0]        stall_q, stall_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              if_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              force_if;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= IDLE;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    owner_d = IDLE;
    if (if_gnt) begin
      owner_d = FETCH;
    end else if (d_gnt) begin
      owner_d = DATA;
    end
  end

  // Grants are forced low while reset is asserted so no store can slip through.
  always_comb begin
    force_if = (stall_q == StallMax);
    if_gnt   = rst_n & if_req & (~d_req | force_if);
    d_gnt    = rst_n & d_req & ~if_gnt;
    mem_we   = 1'b0;
    mem_addr = last_addr_q;
    mem_wd   = '0;
    if (d_gnt) begin
      mem_we   = d_we;
      mem_addr = d_addr;
      mem_wd   = d_wdata;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  always_comb begin
    stall_d     = '0;
    last_addr_d = mem_addr;
    if (if_req && !if_gnt) begin
      stall_d = force_if ? stall_q : stall_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q     <= '0;
      last_addr_q <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      stall_q     <= stall_d;
      last_addr_q <= last_addr_d;
      if_rvalid_q <= if_gnt;
      d_rvalid_q  <= d_gnt;
      if (if_gnt) begin
        if_rdata_q <= mem_rd;
      end
      // Stores leave the previous load data visible.
      if (d_gnt && !d_we) begin
        d_rdata_q <= mem_rd;
      end
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  ownerMatchesFetch: assert property (@(posedge clk) disable iff (!rst_n)
    (owner_q == FETCH) == if_rvalid_q);
  ownerMatchesData: assert property (@(posedge clk) disable iff (!rst_n)
    (owner_q == DATA) == d_rvalid_q);
  singleGrant: assert property (@(posedge clk) disable iff (!rst_n)
    !(if_gnt && d_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port memory.
// Vector table covers the main cycle-by-cycle behaviour; reset cases are hand-written.
module tb_mem_port_arbiter;

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] ST = 32'h12345678;
  localparam logic [31:0] CF = 32'hCAFEF00D;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] memArray [0:255];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic        expIfGnt;
    logic        expDGnt;
    logic        expMemWe;
    logic [31:0] expMemAddr;
    logic        expIfRvalid;
    logic [31:0] expIfRdata;
    logic        expDRvalid;
    logic [31:0] expDRdata;
  } vector_t;

  vector_t vectors[$];

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_STALL(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_gnt(if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_gnt(d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory: combinational read, write on the rising edge.
  assign mem_rd = memArray[8'(mem_addr >> 2)];
  always @(posedge clk) begin
    if (mem_we) begin
      memArray[8'(mem_addr >> 2)] <= mem_wd;
    end
  end

  function automatic vector_t mkVec(
    input logic ifReq, input logic [31:0] ifAddr,
    input logic dReq, input logic dWe, input logic [31:0] dAddr, input logic [31:0] dWdata,
    input logic eIfGnt, input logic eDGnt, input logic eWe, input logic [31:0] eAddr,
    input logic eIfV, input logic [31:0] eIfRd, input logic eDV, input logic [31:0] eDRd);
    vector_t v;
    v.ifReq = ifReq;       v.ifAddr = ifAddr;
    v.dReq = dReq;         v.dWe = dWe;
    v.dAddr = dAddr;       v.dWdata = dWdata;
    v.expIfGnt = eIfGnt;   v.expDGnt = eDGnt;
    v.expMemWe = eWe;      v.expMemAddr = eAddr;
    v.expIfRvalid = eIfV;  v.expIfRdata = eIfRd;
    v.expDRvalid = eDV;    v.expDRdata = eDRd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vector_t v);
    if_req  = v.ifReq;
    if_addr = v.ifAddr;
    d_req   = v.dReq;
    d_we    = v.dWe;
    d_addr  = v.dAddr;
    d_wdata = v.dWdata;
  endtask

  task automatic checkVector(input vector_t v, input int idx);
    checkOutput($sformatf("v%0d if_gnt", idx), 64'(if_gnt), 64'(v.expIfGnt));
    checkOutput($sformatf("v%0d d_gnt", idx), 64'(d_gnt), 64'(v.expDGnt));
    checkOutput($sformatf("v%0d mem_we", idx), 64'(mem_we), 64'(v.expMemWe));
    checkOutput($sformatf("v%0d mem_addr", idx), 64'(mem_addr), 64'(v.expMemAddr));
    checkOutput($sformatf("v%0d if_rvalid", idx), 64'(if_rvalid), 64'(v.expIfRvalid));
    checkOutput($sformatf("v%0d if_rdata", idx), 64'(if_rdata), 64'(v.expIfRdata));
    checkOutput($sformatf("v%0d d_rvalid", idx), 64'(d_rvalid), 64'(v.expDRvalid));
    checkOutput($sformatf("v%0d d_rdata", idx), 64'(d_rdata), 64'(v.expDRdata));
  endtask

  task automatic driveBoth();
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_wdata = 32'h0;
  endtask

  task automatic driveIdle();
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) memArray[i] = 32'h0;
    memArray[8'h10] = DB;

    // Table columns: inputs | if_gnt d_gnt mem_we mem_addr | if_rvalid if_rdata d_rvalid d_rdata
    vectors.push_back(mkVec(0, 32'h0,  0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h0,  0, 32'h0, 0, 32'h0));
    vectors.push_back(mkVec(1, 32'h40, 0, 0, 32'h0,  32'h0, 1, 0, 0, 32'h40, 0, 32'h0, 0, 32'h0));
    vectors.push_back(mkVec(0, 32'h0,  0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h40, 1, DB, 0, 32'h0));
    vectors.push_back(mkVec(0, 32'h0,  1, 1, 32'h80, ST,    0, 1, 1, 32'h80, 0, DB, 0, 32'h0));
    vectors.push_back(mkVec(0, 32'h0,  1, 0, 32'h80, 32'h0, 0, 1, 0, 32'h80, 0, DB, 1, 32'h0));
    vectors.push_back(mkVec(0, 32'h0,  0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h80, 0, DB, 1, ST));
    vectors.push_back(mkVec(0, 32'h0,  0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h80, 0, DB, 0, ST));
    vectors.push_back(mkVec(1, 32'h40, 1, 0, 32'h80, 32'h0, 0, 1, 0, 32'h80, 0, DB, 0, ST));
    for (int k = 0; k < 3; k++)
      vectors.push_back(mkVec(1, 32'h40, 1, 0, 32'h80, 32'h0, 0, 1, 0, 32'h80, 0, DB, 1, ST));
    vectors.push_back(mkVec(1, 32'h40, 1, 0, 32'h80, 32'h0, 1, 0, 0, 32'h40, 0, DB, 1, ST));
    vectors.push_back(mkVec(1, 32'h40, 1, 0, 32'h80, 32'h0, 0, 1, 0, 32'h80, 1, DB, 0, ST));
    vectors.push_back(mkVec(1, 32'h40, 0, 0, 32'h0,  32'h0, 1, 0, 0, 32'h40, 0, DB, 1, ST));
    vectors.push_back(mkVec(1, 32'h40, 1, 1, 32'h40, CF,    0, 1, 1, 32'h40, 1, DB, 0, ST));
    vectors.push_back(mkVec(1, 32'h40, 0, 0, 32'h0,  32'h0, 1, 0, 0, 32'h40, 0, DB, 1, ST));
    vectors.push_back(mkVec(0, 32'h0,  0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h40, 1, CF, 0, ST));
    vectors.push_back(mkVec(0, 32'h0,  1, 0, 32'h83, 32'h0, 0, 1, 0, 32'h83, 0, CF, 0, ST));
    vectors.push_back(mkVec(0, 32'h0,  0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h83, 0, CF, 1, ST));
    for (int k = 0; k < 5; k++)
      vectors.push_back(mkVec(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h83, 0, CF, 0, ST));
    vectors.push_back(mkVec(1, 32'h40, 1, 0, 32'h80, 32'h0, 0, 1, 0, 32'h80, 0, CF, 0, ST));
    vectors.push_back(mkVec(0, 32'h0,  0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h80, 0, CF, 1, ST));
    vectors.push_back(mkVec(0, 32'h0,  0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h80, 0, CF, 0, ST));
    vectors.push_back(mkVec(1, 32'h40, 1, 0, 32'h80, 32'h0, 0, 1, 0, 32'h80, 0, CF, 0, ST));
    for (int k = 0; k < 2; k++)
      vectors.push_back(mkVec(1, 32'h40, 1, 0, 32'h80, 32'h0, 0, 1, 0, 32'h80, 0, CF, 1, ST));
    vectors.push_back(mkVec(0, 32'h0,  1, 0, 32'h80, 32'h0, 0, 1, 0, 32'h80, 0, CF, 1, ST));
    for (int k = 0; k < 4; k++)
      vectors.push_back(mkVec(1, 32'h40, 1, 0, 32'h80, 32'h0, 0, 1, 0, 32'h80, 0, CF, 1, ST));
    vectors.push_back(mkVec(1, 32'h40, 1, 0, 32'h80, 32'h0, 1, 0, 0, 32'h40, 0, CF, 1, ST));
    vectors.push_back(mkVec(0, 32'h0,  0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h40, 1, CF, 0, ST));

    // Reset with both requesters active: grants and write enable must stay low.
    rst_n = 1'b0;
    driveBoth();
    d_we = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset if_gnt", 64'(if_gnt), 64'(0));
    checkOutput("reset d_gnt", 64'(d_gnt), 64'(0));
    checkOutput("reset mem_we", 64'(mem_we), 64'(0));
    checkOutput("reset if_rvalid", 64'(if_rvalid), 64'(0));
    checkOutput("reset d_rvalid", 64'(d_rvalid), 64'(0));
    checkOutput("reset if_rdata", 64'(if_rdata), 64'(0));
    checkOutput("reset d_rdata", 64'(d_rdata), 64'(0));
    driveIdle();
    rst_n = 1'b1;

    for (int i = 0; i < vectors.size(); i++) begin
      @(negedge clk);
      applyStimulus(vectors[i]);
      #2;
      checkVector(vectors[i], i);
    end

    // Asynchronous reset in the cycle after a fetch grant.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40;
    #2 checkOutput("rst1 fetch gnt", 64'(if_gnt), 64'(1));
    @(negedge clk);
    if_req = 1'b0;
    #2 checkOutput("rst1 rvalid before reset", 64'(if_rvalid), 64'(1));
    rst_n = 1'b0;
    #1 checkOutput("rst1 if_rvalid async clear", 64'(if_rvalid), 64'(0));
    checkOutput("rst1 if_rdata async clear", 64'(if_rdata), 64'(0));
    driveBoth();
    d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hBAD0BAD0;
    #1 checkOutput("rst1 if_gnt held low", 64'(if_gnt), 64'(0));
    checkOutput("rst1 d_gnt held low", 64'(d_gnt), 64'(0));
    checkOutput("rst1 mem_we held low", 64'(mem_we), 64'(0));
    @(negedge clk);
    driveIdle();
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h40;
    #2 checkOutput("rst1 refetch gnt", 64'(if_gnt), 64'(1));
    checkOutput("rst1 refetch addr", 64'(mem_addr), 64'(32'h40));
    @(negedge clk);
    if_req = 1'b0;
    #2 checkOutput("rst1 refetch rvalid", 64'(if_rvalid), 64'(1));
    checkOutput("rst1 refetch rdata", 64'(if_rdata), 64'(CF));

    // Reset while the stall counter is part-way up must restart the count.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      driveBoth();
      #2 checkOutput($sformatf("rst2 pre d_gnt %0d", k), 64'(d_gnt), 64'(1));
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 driveIdle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      driveBoth();
      #2;
      checkOutput($sformatf("rst2 post if_gnt %0d", k), 64'(if_gnt), 64'(k == 4));
      checkOutput($sformatf("rst2 post d_gnt %0d", k), 64'(d_gnt), 64'(k < 4));
    end
    @(negedge clk);
    driveIdle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the instruction-fetch requester and the data (load/store) requester of the multi-cycle core.
- Grants at most one access per cycle and drives the memory's write-enable, address and write-data inputs.
- Registers the read data and returns it one cycle after grant, with a per-requester valid pulse.
- Data accesses have priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width.
- MAX_STALL, 4, number of consecutive cycles fetch may be denied while requesting before it is forced to win (range 1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with a stable if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  fetch granted this cycle (combinational).
- if_rvalid  out  1  fetch read data valid (registered).
- if_rdata  out  DATA_W  fetch read data (registered).
- d_req  in  1  data request; d_we, d_addr and d_wdata held stable until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data granted this cycle (combinational).
- d_rvalid  out  1  data access complete (registered); pulses for both loads and stores.
- d_rdata  out  DATA_W  load data (registered).
- mem_we  out  1  to memory write enable.
- mem_addr  out  ADDR_W  to memory address.
- mem_wd  out  DATA_W  to memory write data.
- mem_rd  in  DATA_W  from memory; combinational read of mem_addr.

Behaviour:
- Reset values: if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0, stall_cnt=0, owner=IDLE.
- Grant outputs during reset are 0, and mem_we=0.

Arbitration (combinational, each cycle):
- force_if = (stall_cnt == MAX_STALL).
- if_gnt = if_req & (~d_req | force_if).
- d_gnt = d_req & ~if_gnt.
- Never both granted in the same cycle.

Memory drive:
- d_gnt: mem_addr=d_addr, mem_wd=d_wdata, mem_we=d_we.
- if_gnt: mem_addr=if_addr, mem_we=0.
- No grant: mem_addr holds the last granted address, mem_wd=0, mem_we=0.
- A store therefore writes on the clock edge that ends its grant cycle.

Response (registered):
- On the edge ending an if_gnt cycle: if_rdata<=mem_rd, if_rvalid<=1.
- On the edge ending a d_gnt cycle: d_rdata<=mem_rd if ~d_we, otherwise d_rdata is held; d_rvalid<=1.
- Each rvalid is a one-cycle pulse and is cleared on the next edge unless the same requester is granted again.
- Latency is grant + 1 cycle. Back-to-back grants to one requester yield back-to-back rvalid pulses.
- Read-after-write: a load granted the cycle after a store to the same address returns the new data.

owner state machine (IDLE / FETCH / DATA), holding the last cycle's winner for debug and the stall logic:
- Next state is FETCH if if_gnt, DATA if d_gnt, otherwise IDLE.

stall_cnt:
- Increments (saturating at MAX_STALL) when if_req & ~if_gnt.
- Clears to 0 on if_gnt or when if_req=0.

Boundary conditions:
- Simultaneous requests with stall_cnt<MAX_STALL: data wins.
- Simultaneous requests with stall_cnt==MAX_STALL: fetch wins; data waits exactly one cycle.
- A request dropped before grant is legal; no response is produced.
- A protocol violation (address changes before grant) is not detected; the access uses the address present in the grant cycle.
- Address alignment is not checked; the low two bits pass through unchanged.
- Asynchronous reset mid-access clears all pending rvalid pulses and the counter immediately. A store whose grant edge coincides with reset assertion is not guaranteed.

Test Plan:
- Preload memory word 0x10 = 0xDEADBEEF. Fetch-only: if_req=1, if_addr=0x40 -> if_gnt same cycle; next cycle if_rvalid=1, if_rdata=0xDEADBEEF; mem_we=0 throughout.
- Store then load: d_req with d_we=1, d_addr=0x80, d_wdata=0x12345678, then d_we=0 to 0x80 on the next cycle -> d_rvalid pulses on two consecutive cycles; the second pulse shows d_rdata=0x12345678.
- Contention, MAX_STALL=4: if_req and d_req held high continuously -> d_gnt for 4 cycles, if_gnt on cycle 5, then d_gnt resumes. stall_cnt sequence is 0,1,2,3,4,0.
- Idle bus: no requests for 5 cycles -> no grants, mem_we=0, both rvalid=0, owner=IDLE.
- Reset mid-operation: assert rst_n=0 in the cycle after a fetch grant -> if_rvalid drops immediately, stall_cnt=0. After release, a fetch to 0x40 completes in 2 cycles.
- Write-then-fetch same address: store 0xCAFEF00D to 0x40 granted, fetch 0x40 granted next cycle -> if_rdata=0xCAFEF00D.
